// File: rtl/collector_pkg.sv
// rtl/collector_pkg.sv - shared defaults and sizing helpers for the result collector
package collector_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_RESULT_WIDTH = 16;

    // Occupancy counters need one extra bit so that "full" is distinct from "empty".
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int sat_max(input int width);
        return (2 ** (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(2 ** (width - 1));
    endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - first-word fall-through buffer with drop-on-full writes
module result_fifo
    import collector_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_ready,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  push;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign rd_valid = !empty;
    assign pop      = rd_valid && rd_ready;
    // A pop on the same edge frees the slot, so a full buffer still accepts.
    assign push     = wr_valid && (!full || pop);
    assign drop     = wr_valid && full && !pop;
    assign rd_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - requantizes chain results into a FWFT buffer; RESULT_RELU_EN clamps negatives to zero
module result_collector
    import collector_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int RESULT_WIDTH = DEFAULT_RESULT_WIDTH,
    parameter int FIFO_DEPTH   = 8,
    parameter int SHIFT        = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [RESULT_WIDTH:0]              input_result,
    output logic [DATA_WIDTH-1:0]              output_data,
    output logic                               output_valid,
    input  logic                               output_ready,
    output logic [count_width(FIFO_DEPTH)-1:0] fifo_count,
    output logic                               overflow
);

    // Compare in a width that holds both the shifted result and the clamp bounds.
    localparam int EW = ((RESULT_WIDTH > DATA_WIDTH) ? RESULT_WIDTH : DATA_WIDTH) + 1;
    localparam logic signed [EW-1:0] SAT_HI = EW'(sat_max(DATA_WIDTH));
    localparam logic signed [EW-1:0] SAT_LO = EW'(sat_min(DATA_WIDTH));

    logic signed [RESULT_WIDTH-1:0] shifted;
    logic signed [EW-1:0]           widened;
    logic [DATA_WIDTH-1:0]          requant;
    logic                           s1_valid;
    logic [DATA_WIDTH-1:0]          s1_data;
    logic                           drop;

    always_comb begin
        shifted = $signed(input_result[RESULT_WIDTH-1:0]) >>> SHIFT;
`ifdef RESULT_RELU_EN
        if (shifted[RESULT_WIDTH-1]) begin
            shifted = '0;
        end
`endif
        widened = EW'(shifted);
        if (widened > SAT_HI) begin
            requant = SAT_HI[DATA_WIDTH-1:0];
        end else if (widened < SAT_LO) begin
            requant = SAT_LO[DATA_WIDTH-1:0];
        end else begin
            requant = widened[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= input_result[RESULT_WIDTH];
            s1_data  <= requant;
        end
    end

    result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (s1_valid),
        .wr_data  (s1_data),
        .rd_ready (output_ready),
        .rd_data  (output_data),
        .rd_valid (output_valid),
        .count    (fifo_count),
        .drop     (drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - queue-model scoreboard plus directed scenarios for result_collector
module tb_result_collector;

    localparam int DW    = 8;
    localparam int RW    = 16;
    localparam int DEPTH = 8;
    localparam int SH    = 4;
`ifdef RESULT_RELU_EN
    localparam int NEG_EXP = 0;
`else
    localparam int NEG_EXP = -128;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [RW-1:0] in_data = '0;
    logic          output_ready = 1'b0;
    logic [RW:0]   input_result;
    logic [DW-1:0] output_data;
    logic          output_valid;
    logic [3:0]    fifo_count;
    logic          overflow;

    int n_chk  = 0;
    int n_fail = 0;

    assign input_result = {in_valid, in_data};

    always #5 clk = ~clk;

    result_collector #(
        .DATA_WIDTH   (DW),
        .RESULT_WIDTH (RW),
        .FIFO_DEPTH   (DEPTH),
        .SHIFT        (SH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .input_result (input_result),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, $signed(act), $signed(exp), $time);
        end
    endtask

    // Floor division by 2^SH, optional ReLU, then clamp to the signed output range.
    function automatic int requant(input logic [RW-1:0] r);
        int v;
        int d;
        int s;
        v = int'($signed(r));
        d = 1 << SH;
        if (v >= 0) s = v / d;
        else s = -((-v + d - 1) / d);
`ifdef RESULT_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    int q[$];
    bit pend_v;
    int pend_d;
    bit m_ovf;
    bit m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            pend_v = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_pop = (q.size() > 0) && output_ready;
            if (m_pop) void'(q.pop_front());
            if (pend_v) begin
                if (q.size() < DEPTH) q.push_back(pend_d);
                else m_ovf = 1'b1;
            end
            pend_v = in_valid;
            pend_d = requant(in_data);
        end
    end

    function automatic logic [31:0] sdata();
        return {{(32-DW){output_data[DW-1]}}, output_data};
    endfunction

    always @(negedge clk) begin
        check("sb_valid", {31'd0, output_valid}, {31'd0, q.size() > 0});
        check("sb_count", {28'd0, fifo_count}, q.size());
        check("sb_overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (q.size() > 0) check("sb_data", sdata(), q[0]);
        else if (rst) check("sb_rst_data", {24'd0, output_data}, 0);
    end

    task automatic cyc(input bit v, input logic [RW-1:0] d, input bit rdy);
        in_valid     = v;
        in_data      = d;
        output_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, '0, 0);
        cyc(0, '0, 0);
        rst = 1'b0;
    endtask

    initial begin
        int p;
        @(posedge clk);
        #2;
        do_reset();
        check("reset_valid", {31'd0, output_valid}, 0);
        check("reset_count", {28'd0, fifo_count}, 0);
        check("reset_overflow", {31'd0, overflow}, 0);
        check("reset_data", {24'd0, output_data}, 0);

        check("model_200", requant(16'd200), 12);
        check("model_4000", requant(16'd4000), 127);
        check("model_neg4000", requant(-16'd4000), NEG_EXP);

        // Two-edge latency, valid for exactly one cycle
        cyc(1, 16'd200, 1);
        check("lat_after_n", {31'd0, output_valid}, 0);
        cyc(0, '0, 1);
        check("lat_after_n1_valid", {31'd0, output_valid}, 1);
        check("lat_after_n1_data", sdata(), 12);
        cyc(0, '0, 1);
        check("lat_after_n2_valid", {31'd0, output_valid}, 0);

        // Saturation at both ends
        cyc(1, 16'd4000, 0);
        cyc(0, '0, 0);
        check("sat_hi", sdata(), 127);
        cyc(1, -16'd4000, 1);
        cyc(0, '0, 1);
        check("sat_lo_valid", {31'd0, output_valid}, 1);
        check("sat_lo", sdata(), NEG_EXP);
        cyc(0, '0, 1);

        // Overrun: 10 writes into 8 slots
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, RW'(i * 16), 0);
        cyc(0, '0, 0);
        check("ovr_count", {28'd0, fifo_count}, 8);
        check("ovr_flag", {31'd0, overflow}, 1);
        for (int i = 0; i < 8; i++) begin
            check("ovr_drain", sdata(), i);
            cyc(0, '0, 1);
        end
        check("ovr_empty", {31'd0, output_valid}, 0);
        check("ovr_sticky", {31'd0, overflow}, 1);

        // Full with simultaneous pop accepts the write
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1, RW'(i * 16), 0);
        cyc(0, '0, 0);
        cyc(1, 16'd800, 0);
        check("fp_count_pre", {28'd0, fifo_count}, 8);
        cyc(0, '0, 1);
        check("fp_count", {28'd0, fifo_count}, 8);
        check("fp_overflow", {31'd0, overflow}, 0);
        for (int i = 2; i <= 9; i++) begin
            check("fp_drain", sdata(), (i == 9) ? 50 : i);
            cyc(0, '0, 1);
        end
        check("fp_empty", {31'd0, output_valid}, 0);

        // Mid-operation reset discards buffered and in-flight results
        do_reset();
        for (int i = 1; i <= 6; i++) cyc(1, RW'(i * 16), 0);
        check("mr_count_pre", {28'd0, fifo_count}, 5);
        rst = 1'b1;
        #1;
        check("mr_count", {28'd0, fifo_count}, 0);
        check("mr_valid", {31'd0, output_valid}, 0);
        cyc(0, '0, 0);
        rst = 1'b0;
        cyc(1, 16'd112, 1);
        check("mr_lat_n", {31'd0, output_valid}, 0);
        cyc(0, '0, 1);
        check("mr_lat_n1", sdata(), 7);
        check("mr_alone", {28'd0, fifo_count}, 1);
        cyc(0, '0, 1);
        check("mr_done", {28'd0, fifo_count}, 0);

        // Invalid inputs never write
        repeat (20) cyc(0, 16'hFFFF, 1);
        check("inv_count", {28'd0, fifo_count}, 0);
        check("inv_valid", {31'd0, output_valid}, 0);

        // Randomized traffic with varying consumer pressure
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            case (ph % 3)
                0: p = 10;
                1: p = 50;
                default: p = 90;
            endcase
            for (int k = 0; k < 500; k++) begin
                rst = ($urandom_range(0, 299) == 0);
                cyc($urandom_range(0, 99) < 70, RW'($urandom), $urandom_range(0, 99) < p);
            end
        end
        rst = 1'b0;
        repeat (3) cyc(0, '0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_WIDTH, default 8: width of each requantized output value.
REQ-003 Parameter RESULT_WIDTH, default 16: width of the accumulated result payload.
REQ-004 Parameter FIFO_DEPTH, default 8: output buffer entries; power of two, minimum 2.
REQ-005 Parameter SHIFT, default 4: arithmetic right-shift applied before saturation; range 0..RESULT_WIDTH-1.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst, input, 1: asynchronous active-high reset.
REQ-008 Port input_result, input, RESULT_WIDTH+1: bit RESULT_WIDTH is the valid flag; bits RESULT_WIDTH-1:0 are a signed two's-complement result from the last compute cell in the chain.
REQ-009 Port output_data, output, DATA_WIDTH: signed requantized value at the FIFO head.
REQ-010 Port output_valid, output, 1: output_data holds a valid entry.
REQ-011 Port output_ready, input, 1: the consumer accepts the head entry.
REQ-012 Port fifo_count, output, $clog2(FIFO_DEPTH)+1: number of occupied entries.
REQ-013 Port overflow, output, 1: sticky flag; one or more results were dropped.

Function
REQ-014 The block SHALL capture a result on every rising edge where input_result[RESULT_WIDTH]=1, with no back-pressure toward the cell chain.
REQ-015 Stage 1 SHALL register the value arithmetically shifted right by SHIFT, sign preserved.
REQ-016 Stage 1 SHALL saturate the shifted value to the signed DATA_WIDTH range: above 2^(DATA_WIDTH-1)-1 clamps to max, below -2^(DATA_WIDTH-1) clamps to min.
REQ-017 Stage 2 SHALL write the stage-1 value into the FIFO on the following edge.
REQ-018 Latency: a result valid before edge N SHALL appear as output_valid=1 after edge N+1 if the FIFO was empty (first-word fall-through).
REQ-019 A pop SHALL occur on an edge where output_valid=1 and output_ready=1.
REQ-020 While output_valid=1 and output_ready=0, output_data SHALL remain stable.
REQ-021 Full without a pop: the write SHALL be dropped, overflow SHALL be set, and fifo_count SHALL be unchanged.
REQ-022 Full with a simultaneous pop: the write SHALL be accepted and fifo_count SHALL stay at FIFO_DEPTH.
REQ-023 Empty with a simultaneous write: output_valid SHALL stay 0 that cycle, with no pop.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 fifo_count SHALL equal writes minus pops since reset, never exceeding FIFO_DEPTH.
REQ-026 overflow SHALL remain 1 until reset.

Reset
REQ-027 While rst=1, the block SHALL drive output_data=0, output_valid=0, fifo_count=0 and overflow=0, clear both pointers, and invalidate stage 1.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and in-flight results; the first capture after release follows REQ-018.

Configuration
REQ-029 With RESULT_RELU_EN defined, negative shifted values SHALL become 0 before saturation, so output_data is in 0..2^(DATA_WIDTH-1)-1.
REQ-030 Without RESULT_RELU_EN, the block SHALL apply signed saturation only, with no ReLU logic present.

Structure
REQ-031 Package collector_pkg SHALL hold the default DATA_WIDTH/RESULT_WIDTH constants, the saturation bound constants and the count-width function.
REQ-032 The buffer SHALL be sub-module result_fifo: synchronous first-word fall-through, with the full/empty/count logic inside it.

Verification
REQ-033 Scenario: input_result={1,16'd200}, SHIFT=4, output_ready=1 -> output_data=12, output_valid high exactly one cycle, after edge N+1.
REQ-034 Scenario: input_result={1,16'd4000} -> output_data=127; {1,-16'd4000} -> -128 without RESULT_RELU_EN, 0 with it.
REQ-035 Scenario: 10 back-to-back valid results, output_ready=0, depth 8 -> fifo_count=8, overflow=1, first 8 values drained in order.
REQ-036 Scenario: FIFO full, output_ready=1 with a simultaneous valid input -> fifo_count stays 8, overflow stays 0, new value appears last.
REQ-037 Scenario: rst pulse with 5 entries buffered and one result in stage 1 -> count 0, output_valid 0; the next result is delivered alone with 2-cycle latency.
REQ-038 Scenario: input_result={0,16'hFFFF} for 20 cycles -> no writes, fifo_count=0.
